uart_tx_fifo_drain: RTL and testbench
=====================================

Name: uart_tx_fifo_drain

Overview:
- Transmit-side consumer of the 256x8 UART FIFO. The APB side writes bytes into the FIFO; this block pops them and serialises each byte onto TX.
- Serial frame is start bit, 7 or 8 data bits (LSB first), optional parity bit, then one stop bit.
- Timing comes from the shared 16x oversampling baud tick. The block sits between the TX FIFO and the UART TX pin.

Parameters:
- OVERSAMPLE, 16, number of BAUD_EN pulses per serial bit (range 2..255).
- RD_LATENCY, 2, CLK edges from the FIFO_RDB-low cycle until FIFO_DATA is valid (range 1..3).

Ports:
- CLK  in  1  system clock; everything is sampled on the rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- BAUD_EN  in  1  one-CLK pulse at 16x baud rate.
- FIFO_EMPTY  in  1  FIFO empty flag.
- FIFO_DATA  in  8  FIFO read data.
- FIFO_RDB  out  1  active-low FIFO read strobe, one CLK per pop.
- BIT8  in  1  1 = 8 data bits, 0 = 7 data bits (bit 7 not sent).
- PARITY_EN  in  1  1 = append parity bit.
- ODD_N_EVEN  in  1  1 = odd parity, 0 = even parity.
- TX  out  1  serial output; idles high.
- TX_BUSY  out  1  high from the pop until the end of the stop bit.

Behaviour:
- Reset (asynchronous, RESET_N low): TX=1, FIFO_RDB=1, TX_BUSY=0, state=IDLE, all counters 0, shift register 0. Takes effect immediately, including mid-frame. TX returns high with no glitch to 0.
- Frame configuration: BIT8, PARITY_EN and ODD_N_EVEN are captured in LOAD and held for the whole frame. Changing them mid-frame has no effect on the frame in progress.
- States:
  - IDLE: if FIFO_EMPTY=0, drive FIFO_RDB=0 for exactly one CLK, set TX_BUSY=1, go to WAIT. Otherwise stay.
  - WAIT: count RD_LATENCY-1 CLKs with FIFO_RDB=1, then go to LOAD.
  - LOAD: capture FIFO_DATA into the shift register and compute parity = XOR of the sent data bits XOR ODD_N_EVEN. Clear the tick counter, go to START.
  - START: TX=0 for OVERSAMPLE BAUD_EN pulses, then go to DATA.
  - DATA: TX = shift[0]. After OVERSAMPLE pulses, shift right and increment the bit counter. After 8 bits (BIT8=1) or 7 bits (BIT8=0), go to PARITY if PARITY_EN=1, otherwise go to STOP.
  - PARITY: TX = parity bit for OVERSAMPLE pulses, then go to STOP.
  - STOP: TX=1 for OVERSAMPLE pulses. Then:
    - if FIFO_EMPTY=0, issue the next pop directly (FIFO_RDB=0 one CLK) and go to WAIT with TX_BUSY held at 1;
    - otherwise TX_BUSY=0 and go to IDLE.
- Gap between frames: with a non-empty FIFO, TX stays high for exactly the stop bit plus RD_LATENCY+1 CLKs. The gap does not wait for a baud tick.
- Counting rules:
  - The tick counter is $clog2(OVERSAMPLE) bits wide and advances only on BAUD_EN.
  - The bit counter is 3 bits and compares against 7 or 6 for the last bit.
  - TX changes only on the CLK edge after a BAUD_EN that completes a bit period. Exception: entry to START happens in the CLK after LOAD.
- Read strobe rule: FIFO_RDB is never low while FIFO_EMPTY=1 and never low for two consecutive CLKs. Exactly one pop per frame, so the FIFO can never underflow through this block.
- FIFO_EMPTY asserting during WAIT (the FIFO just drained): the frame still completes using the captured byte.
- BAUD_EN held constantly high: the block still works, with bit period = OVERSAMPLE CLKs.
- Reset mid-operation: a byte already popped is lost. No re-pop happens after reset.

Test Plan:
- Reset, FIFO empty, 100 CLKs → TX=1, FIFO_RDB=1, TX_BUSY=0 throughout.
- Load 0xA5 with BIT8=1, PARITY_EN=0, BAUD_EN every CLK → one FIFO_RDB low pulse; TX = 0,1,0,1,0,0,1,0,1,1, each bit 16 CLKs; TX_BUSY falls after the stop bit.
- 0x03 with BIT8=0, PARITY_EN=1, ODD_N_EVEN=1 → 7 data bits 1,1,0,0,0,0,0, then parity=1 and stop; frame is 10 bits.
- 0x03 with BIT8=1, PARITY_EN=1, even parity → parity bit 0, frame is 11 bits.
- Load 3 bytes 0x11, 0x22, 0x33 back-to-back → three frames in order; exactly 3 FIFO_RDB pulses; TX_BUSY stays high continuously; FIFO_EMPTY=1 at the end.
- Assert RESET_N=0 during data bit 4 of 0x55 → TX=1 immediately, TX_BUSY=0. After release with the FIFO empty, no FIFO_RDB pulse occurs.

Source files
------------

// File: rtl/uart_tx_fifo_drain_if.sv
// FIFO read port, baud tick, frame configuration and serial outputs of the TX drain.
// The drain uses the master modport; the FIFO/pin side uses the slave modport.
interface uart_tx_fifo_drain_if;
    logic       baud_en;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_rdb;
    logic       bit8;
    logic       parity_en;
    logic       odd_n_even;
    logic       tx;
    logic       tx_busy;

    modport master (
        input  baud_en,
        input  fifo_empty,
        input  fifo_data,
        input  bit8,
        input  parity_en,
        input  odd_n_even,
        output fifo_rdb,
        output tx,
        output tx_busy
    );

    modport slave (
        output baud_en,
        output fifo_empty,
        output fifo_data,
        output bit8,
        output parity_en,
        output odd_n_even,
        input  fifo_rdb,
        input  tx,
        input  tx_busy
    );
endinterface

// File: rtl/uart_tx_fifo_drain.sv
// UART transmit drain: pops one byte per frame from the TX FIFO and serialises it as
// start bit, 7/8 data bits LSB first, optional parity bit and one stop bit.
// Bit timing comes from the shared oversampled baud tick; all outputs are registered.
module uart_tx_fifo_drain #(
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    uart_tx_fifo_drain_if.master bus
);

    localparam int unsigned      TickW    = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [TickW-1:0] TickLast = TickW'(OVERSAMPLE - 1);
    // WAIT spans the strobe cycle plus RD_LATENCY-1 further cycles.
    localparam logic [1:0]       WaitLast = 2'(RD_LATENCY - 1);

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StLoad,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e           state_q, state_d;
    logic [TickW-1:0] tick_q, tick_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [1:0]       wait_cnt_q, wait_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             parity_q, parity_d;
    logic             bit8_q, bit8_d;
    logic             par_en_q, par_en_d;
    logic             tx_q, tx_d;
    logic             rdb_q, rdb_d;
    logic             busy_q, busy_d;

    logic             timed_state;
    logic             tick_done;
    logic             last_bit;
    logic [7:0]       load_data;

    // A bit period ends on the baud pulse that brings the tick counter to its last value.
    assign timed_state = (state_q == StStart) || (state_q == StData) ||
                         (state_q == StParity) || (state_q == StStop);
    assign tick_done   = bus.baud_en && (tick_q == TickLast);
    assign last_bit    = (bit_cnt_q == (bit8_q ? 3'd7 : 3'd6));
    // In 7-bit mode bit 7 is neither sent nor counted in the parity.
    assign load_data   = bus.bit8 ? bus.fifo_data : {1'b0, bus.fifo_data[6:0]};

    // Next-state and registered-output logic for the frame sequencer.
    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        bit_cnt_d  = bit_cnt_q;
        wait_cnt_d = wait_cnt_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        bit8_d     = bit8_q;
        par_en_d   = par_en_q;
        tx_d       = tx_q;
        rdb_d      = 1'b1;
        busy_d     = busy_q;

        if (timed_state && bus.baud_en) begin
            tick_d = tick_done ? '0 : tick_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (!bus.fifo_empty) begin
                    rdb_d      = 1'b0;
                    busy_d     = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = StWait;
                end
            end
            StWait: begin
                if (wait_cnt_q == WaitLast) begin
                    state_d = StLoad;
                end else begin
                    wait_cnt_d = wait_cnt_q + 2'd1;
                end
            end
            StLoad: begin
                // Frame format is frozen here for the whole frame.
                shift_d   = load_data;
                parity_d  = (^load_data) ^ bus.odd_n_even;
                bit8_d    = bus.bit8;
                par_en_d  = bus.parity_en;
                tick_d    = '0;
                bit_cnt_d = '0;
                tx_d      = 1'b0;
                state_d   = StStart;
            end
            StStart: begin
                if (tick_done) begin
                    tx_d    = shift_q[0];
                    state_d = StData;
                end
            end
            StData: begin
                if (tick_done) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (!last_bit) begin
                        tx_d = shift_q[1];
                    end else if (par_en_q) begin
                        tx_d    = parity_q;
                        state_d = StParity;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = StStop;
                    end
                end
            end
            StParity: begin
                if (tick_done) begin
                    tx_d    = 1'b1;
                    state_d = StStop;
                end
            end
            StStop: begin
                if (tick_done) begin
                    if (!bus.fifo_empty) begin
                        // Chain straight into the next pop without dropping busy.
                        rdb_d      = 1'b0;
                        wait_cnt_d = '0;
                        state_d    = StWait;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers; reset forces the line idle immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            tick_q     <= '0;
            bit_cnt_q  <= '0;
            wait_cnt_q <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            bit8_q     <= 1'b0;
            par_en_q   <= 1'b0;
            tx_q       <= 1'b1;
            rdb_q      <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            bit_cnt_q  <= bit_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            bit8_q     <= bit8_d;
            par_en_q   <= par_en_d;
            tx_q       <= tx_d;
            rdb_q      <= rdb_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.tx       = tx_q;
    assign bus.fifo_rdb = rdb_q;
    assign bus.tx_busy  = busy_q;

    // The read strobe is a single-cycle pulse and is only issued against a non-empty FIFO.
    a_rdb_single : assert property (@(posedge clk) disable iff (!rst_n) !rdb_q |=> rdb_q);
    a_rdb_nonempty : assert property (@(posedge clk) disable iff (!rst_n)
                                      !rdb_q |-> !bus.fifo_empty);

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Bench for uart_tx_fifo_drain: a FIFO model with RD_LATENCY read delay, a frame-timeline
// model built from the byte list and baud pattern, and a per-cycle compare of all outputs.
module tb_uart_tx_fifo_drain;

    localparam int OS   = 16;
    localparam int RL   = 2;
    localparam int MAXC = 4096;

    typedef logic [7:0] bytes_t[$];

    logic clk = 1'b0;
    logic rst_n;

    uart_tx_fifo_drain_if bus ();

    uart_tx_fifo_drain #(
        .OVERSAMPLE(OS),
        .RD_LATENCY(RL)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int baud_div = 1;
    int pops     = 0;

    bit exp_tx  [MAXC];
    bit exp_busy[MAXC];
    bit exp_rdb [MAXC];
    bit act_tx  [MAXC];
    bit act_busy[MAXC];

    logic [7:0] fifo_q[$];
    bit         pend1 = 1'b0;
    bit         pend2 = 1'b0;
    logic [7:0] pend_val = 8'h00;

    function automatic bit baud_of(input int n);
        return (n % baud_div) == 0;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic clear_from(input int n);
        for (int i = n; i < MAXC; i++) begin
            exp_tx[i]   = 1'b1;
            exp_busy[i] = 1'b0;
            exp_rdb[i]  = 1'b1;
        end
    endtask

    // Expected waveform for frames popped back to back starting with a pop in cycle pop_c.
    task automatic schedule(input int pop_c, input bytes_t bytes, input bit b8, input bit pen,
                            input bit odd, output int end_c);
        int c;
        int s;
        int n;
        int cnt;
        bit par;
        bit frame[$];
        c = pop_c;
        foreach (bytes[k]) begin
            frame.delete();
            par = odd;
            frame.push_back(1'b0);
            for (int i = 0; i < (b8 ? 8 : 7); i++) begin
                frame.push_back(bytes[k][i]);
                par = par ^ bytes[k][i];
            end
            if (pen) frame.push_back(par);
            frame.push_back(1'b1);
            exp_rdb[c] = 1'b0;
            for (int i = c; i < c + RL + 1; i++) exp_busy[i] = 1'b1;
            s = c + RL + 1;
            foreach (frame[b]) begin
                cnt = 0;
                for (n = s; n < MAXC; n++) begin
                    exp_tx[n]   = frame[b];
                    exp_busy[n] = 1'b1;
                    if (baud_of(n)) cnt++;
                    if (cnt == OS) break;
                end
                s = n + 1;
            end
            c = s;
        end
        end_c = c;
    endtask

    // One clock: compare outputs, advance the FIFO model, drive inputs for the next edge.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (cyc >= MAXC) begin
            $display("FAIL cycle_budget at cycle %0d: got overrun, expected < %0d", cyc, MAXC);
            $fatal(1);
        end
        act_tx[cyc]   = bus.tx;
        act_busy[cyc] = bus.tx_busy;
        check("tx", int'(bus.tx), int'(exp_tx[cyc]));
        check("tx_busy", int'(bus.tx_busy), int'(exp_busy[cyc]));
        check("fifo_rdb", int'(bus.fifo_rdb), int'(exp_rdb[cyc]));
        if (pend2) begin
            bus.fifo_data = pend_val;
            pend2 = 1'b0;
        end
        if (pend1) begin
            pend1 = 1'b0;
            pend_val = fifo_q.pop_front();
            bus.fifo_data = ~pend_val;
            pend2 = 1'b1;
        end
        if (bus.fifo_rdb == 1'b0) begin
            pops++;
            check("rdb_while_empty", int'(fifo_q.size() == 0), 0);
            if (fifo_q.size() != 0) pend1 = 1'b1;
        end
        bus.fifo_empty = (fifo_q.size() == 0);
        bus.baud_en    = baud_of(cyc);
    endtask

    function automatic int sample_frame(input int s0, input int nb);
        int v = 0;
        for (int i = 0; i < nb; i++) v = v | (int'(act_tx[s0 + i * OS + OS / 2]) << i);
        return v;
    endfunction

    function automatic int count_busy(input int a, input int b);
        int n = 0;
        for (int i = a; i < b; i++) n += int'(act_busy[i]);
        return n;
    endfunction

    task automatic run_frames(input bytes_t bytes, input bit b8, input bit pen, input bit odd,
                              input int flip_after, output int pop_c, output int end_c);
        int p0;
        bus.bit8       = b8;
        bus.parity_en  = pen;
        bus.odd_n_even = odd;
        foreach (bytes[k]) fifo_q.push_back(bytes[k]);
        bus.fifo_empty = 1'b0;
        pop_c = cyc + 1;
        p0 = pops;
        schedule(pop_c, bytes, b8, pen, odd, end_c);
        while (cyc < end_c + 8) begin
            step();
            if (flip_after > 0 && cyc == pop_c + flip_after) begin
                bus.bit8       = ~b8;
                bus.parity_en  = ~pen;
                bus.odd_n_even = ~odd;
            end
        end
        check("pop_count_model", pops - p0, bytes.size());
    endtask

    initial begin
        bytes_t b;
        int pc;
        int ec;
        int p0;
        int t;

        rst_n          = 1'b0;
        bus.baud_en    = 1'b0;
        bus.fifo_empty = 1'b1;
        bus.fifo_data  = 8'h00;
        bus.bit8       = 1'b1;
        bus.parity_en  = 1'b0;
        bus.odd_n_even = 1'b0;
        clear_from(0);
        repeat (3) step();
        rst_n = 1'b1;

        // Idle with an empty FIFO.
        repeat (100) step();
        check("idle_pops", pops, 0);

        // 0xA5, 8N1.
        b = {};
        b.push_back(8'hA5);
        p0 = pops;
        run_frames(b, 1'b1, 1'b0, 1'b0, 0, pc, ec);
        check("a5_pops", pops - p0, 1);
        check("a5_frame", sample_frame(pc + RL + 1, 10), 'b1101001010);
        check("a5_busy_len", count_busy(pc, ec + 8), 163);

        // 0x03, 7 bits, odd parity; format flipped mid-frame must not matter.
        b = {};
        b.push_back(8'h03);
        run_frames(b, 1'b0, 1'b1, 1'b1, 40, pc, ec);
        check("p7o_frame", sample_frame(pc + RL + 1, 10), 'b1100000110);
        check("p7o_busy_len", count_busy(pc, ec + 8), 163);

        // 0x03, 8 bits, even parity.
        b = {};
        b.push_back(8'h03);
        run_frames(b, 1'b1, 1'b1, 1'b0, 0, pc, ec);
        check("p8e_frame", sample_frame(pc + RL + 1, 11), 'b10000000110);
        check("p8e_busy_len", count_busy(pc, ec + 8), 179);

        // Three bytes back to back.
        b = {};
        b.push_back(8'h11);
        b.push_back(8'h22);
        b.push_back(8'h33);
        p0 = pops;
        run_frames(b, 1'b1, 1'b0, 1'b0, 0, pc, ec);
        check("b2b_pops", pops - p0, 3);
        check("b2b_busy_len", count_busy(pc, ec + 8), 489);
        check("b2b_frame0", sample_frame(pc + RL + 1, 10), 'b1000100010);
        check("b2b_frame1", sample_frame(pc + 163 + RL + 1, 10), 'b1001000100);
        check("b2b_empty_end", int'(bus.fifo_empty), 1);

        // Sparse baud tick: one pulse every second clock.
        baud_div = 2;
        b = {};
        b.push_back(8'h5A);
        p0 = pops;
        run_frames(b, 1'b1, 1'b1, 1'b1, 0, pc, ec);
        check("slow_pops", pops - p0, 1);
        baud_div = 1;
        repeat (4) step();

        // Reset in the middle of data bit 4 of 0x55.
        b = {};
        b.push_back(8'h55);
        bus.bit8       = 1'b1;
        bus.parity_en  = 1'b0;
        bus.odd_n_even = 1'b0;
        fifo_q.push_back(8'h55);
        bus.fifo_empty = 1'b0;
        pc = cyc + 1;
        p0 = pops;
        schedule(pc, b, 1'b1, 1'b0, 1'b0, ec);
        t = pc + RL + 1 + OS * 5 + OS / 2;
        while (cyc < t) step();
        check("rst_busy_before", int'(bus.tx_busy), 1);
        rst_n = 1'b0;
        #1;
        check("rst_tx_now", int'(bus.tx), 1);
        check("rst_busy_now", int'(bus.tx_busy), 0);
        check("rst_rdb_now", int'(bus.fifo_rdb), 1);
        clear_from(cyc + 1);
        repeat (4) step();
        rst_n = 1'b1;
        repeat (60) step();
        check("rst_pops", pops - p0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
